// File: rtl/sv_interface_impl_vif.sv
// Method-invocation endpoint: registers with the upstream endpoint, then serves inc/blocking calls.
// Optional call tracing is compiled in when SV_IFIMPL_TRACE_EN is defined.
module sv_interface_impl_vif #(
  parameter logic [31:0] INST_ID   = 32'd0,
  parameter logic [31:0] TYPE_ID   = 32'd0,
  parameter int          ID_W      = 16,
  parameter int          BLOCK_LAT = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            def_valid,
  output logic [31:0]     def_inst_id,
  output logic [31:0]     def_type_id,
  input  logic            def_ready,
  input  logic            def_nack,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  input  logic            req_blocking,
  input  logic [31:0]     req_param,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_has_val,
  output logic [31:0]     rsp_val,
  output logic [7:0]      rsp_width,
  output logic            rsp_error,
  output logic            fault,
  output logic [31:0]     inc_count,
  output logic [15:0]     err_count
);

  typedef enum logic [2:0] {
    S_REG     = 3'd0,
    S_IDLE    = 3'd1,
    S_EXEC_NB = 3'd2,
    S_EXEC_B  = 3'd3,
    S_RESP    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(BLOCK_LAT - 1);

  state_t          r_state;
  logic            r_def_valid;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic            r_rsp_has_val;
  logic [31:0]     r_rsp_val;
  logic [7:0]      r_rsp_width;
  logic            r_rsp_error;
  logic            r_fault;
  logic [31:0]     r_inc_count;
  logic [15:0]     r_err_count;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_param;
  logic [7:0]      r_lat_cnt;

  assign def_inst_id = INST_ID;
  assign def_type_id = TYPE_ID;
  assign def_valid   = r_def_valid;
  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_has_val = r_rsp_has_val;
  assign rsp_val     = r_rsp_val;
  assign rsp_width   = r_rsp_width;
  assign rsp_error   = r_rsp_error;
  assign fault       = r_fault;
  assign inc_count   = r_inc_count;
  assign err_count   = r_err_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_REG;
      r_def_valid   <= 1'b0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_has_val <= 1'b0;
      r_rsp_val     <= 32'd0;
      r_rsp_width   <= 8'd0;
      r_rsp_error   <= 1'b0;
      r_fault       <= 1'b0;
      r_inc_count   <= 32'd0;
      r_err_count   <= 16'd0;
      r_id          <= '0;
      r_param       <= 32'd0;
      r_lat_cnt     <= 8'd0;
    end else begin
      case (r_state)
        S_REG: begin
          // The upstream answer only counts once our request is visible; nack beats ready.
          if (r_def_valid && def_nack) begin
            r_def_valid <= 1'b0;
            r_fault     <= 1'b1;
            r_state     <= S_FAULT;
`ifdef SV_IFIMPL_TRACE_EN
            $display("Error: no default endpoint");
`endif
          end else if (r_def_valid && def_ready) begin
            r_def_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_def_valid <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            r_id        <= req_id;
            r_param     <= req_param;
            r_req_ready <= 1'b0;
            r_lat_cnt   <= 8'd0;
            if (req_blocking) begin
              r_state <= S_EXEC_B;
`ifdef SV_IFIMPL_TRACE_EN
              $display("invoke_b");
`endif
            end else begin
              r_state <= S_EXEC_NB;
            end
          end
        end
        S_EXEC_NB: begin
          if (r_id == '0) begin
            r_rsp_val     <= r_param + 32'd1;
            r_rsp_has_val <= 1'b1;
            r_rsp_width   <= 8'd32;
            r_inc_count   <= r_inc_count + 32'd1;
`ifdef SV_IFIMPL_TRACE_EN
            $display("inc %0d", $signed(r_param));
`endif
          end else begin
            r_rsp_error <= 1'b1;
            if (r_err_count != 16'hFFFF) begin
              r_err_count <= r_err_count + 16'd1;
            end
`ifdef SV_IFIMPL_TRACE_EN
            $display("Error: unknown method id %0d", r_id);
`endif
          end
          r_state <= S_RESP;
        end
        S_EXEC_B: begin
          // Response fields are already null from the previous handshake or reset.
          if (r_lat_cnt == LP_LAST) begin
            r_state <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + 8'd1;
          end
        end
        S_RESP: begin
          // Fields were settled on entry; valid follows one cycle later and holds until taken.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_has_val <= 1'b0;
            r_rsp_val     <= 32'd0;
            r_rsp_width   <= 8'd0;
            r_rsp_error   <= 1'b0;
            r_req_ready   <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_FAULT: begin
          r_fault     <= 1'b1;
          r_req_ready <= 1'b0;
        end
        default: begin
          r_state <= S_REG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sv_interface_impl_vif.sv
// Randomized self-checking bench for sv_interface_impl_vif against a call-level reference model.
module tb_sv_interface_impl_vif;

  localparam logic [31:0] P_INST = 32'hA5A5_0012;
  localparam logic [31:0] P_TYPE = 32'h0000_0034;
  localparam int          P_LAT  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        def_valid;
  logic [31:0] def_inst_id;
  logic [31:0] def_type_id;
  logic        def_ready = 1'b0;
  logic        def_nack = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_id = 16'd0;
  logic        req_blocking = 1'b0;
  logic [31:0] req_param = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_has_val;
  logic [31:0] rsp_val;
  logic [7:0]  rsp_width;
  logic        rsp_error;
  logic        fault;
  logic [31:0] inc_count;
  logic [15:0] err_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_inc = 32'd0;
  int          m_err = 0;

  sv_interface_impl_vif #(
    .INST_ID(P_INST), .TYPE_ID(P_TYPE), .ID_W(16), .BLOCK_LAT(P_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .def_valid(def_valid), .def_inst_id(def_inst_id), .def_type_id(def_type_id),
    .def_ready(def_ready), .def_nack(def_nack),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_blocking(req_blocking), .req_param(req_param),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_has_val(rsp_has_val),
    .rsp_val(rsp_val), .rsp_width(rsp_width), .rsp_error(rsp_error),
    .fault(fault), .inc_count(inc_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    def_ready = 1'b0; def_nack = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    m_inc = 32'd0; m_err = 0;
    tick(); tick();
    n_checks++;
    if ({def_valid, req_ready, rsp_valid, rsp_has_val, rsp_error, fault} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {def_valid, req_ready, rsp_valid, rsp_has_val, rsp_error, fault});
    end
    n_checks++;
    if ({rsp_val, rsp_width, inc_count, err_count} !== 88'd0) begin
      n_fail++;
      $display("FAIL reset_values: val=%h width=%0d inc=%0d err=%0d expected all 0",
               rsp_val, rsp_width, inc_count, err_count);
    end
    n_checks++;
    if (def_inst_id !== P_INST || def_type_id !== P_TYPE) begin
      n_fail++;
      $display("FAIL reset_ids: inst=%h type=%h expected %h %h", def_inst_id, def_type_id, P_INST, P_TYPE);
    end
  endtask

  // Releases reset and completes registration with a def_ready pulse.
  task automatic test_register();
    int k;
    reset = 1'b0;
    k = 0;
    while (def_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (def_valid !== 1'b1 || k != 1) begin
      n_fail++;
      $display("FAIL reg_def_valid: def_valid=%b after %0d cycles, expected 1 after 1", def_valid, k);
    end
    n_checks++;
    if (def_inst_id !== P_INST || def_type_id !== P_TYPE || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_fields: inst=%h type=%h req_ready=%b expected %h %h 0",
               def_inst_id, def_type_id, req_ready, P_INST, P_TYPE);
    end
    def_ready = 1'b1;
    tick();
    def_ready = 1'b0;
    n_checks++;
    if (def_valid !== 1'b0 || req_ready !== 1'b1 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_done: def_valid=%b req_ready=%b fault=%b expected 0 1 0", def_valid, req_ready, fault);
    end
  endtask

  // Issues one call, checks latency, response contents, stability while stalled, and counters.
  task automatic do_call(input logic [15:0] id, input logic blk, input logic [31:0] p, input int hold);
    logic        e_has;
    logic [31:0] e_val;
    logic        e_err;
    logic [7:0]  e_w;
    int          e_lat;
    int          k;
    int          lat;
    e_has = 1'b0; e_val = 32'd0; e_err = 1'b0; e_w = 8'd0;
    if (blk) begin
      e_lat = P_LAT + 1;
    end else if (id == 16'd0) begin
      e_has = 1'b1; e_val = p + 32'd1; e_w = 8'd32; e_lat = 2;
      m_inc = m_inc + 32'd1;
    end else begin
      e_err = 1'b1; e_lat = 2;
      if (m_err < 65535) m_err++;
    end
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL call_req_ready: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_id = id; req_blocking = blk; req_param = p;
    tick();
    req_valid = 1'b0; req_id = 16'($urandom); req_blocking = 1'($urandom); req_param = $urandom;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != e_lat) begin
      n_fail++;
      $display("FAIL call_latency id=%0d blk=%b: got %0d cycles expected %0d", id, blk, lat, e_lat);
    end
    for (int h = 0; h <= hold; h++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_has_val !== e_has || rsp_val !== e_val ||
          rsp_width !== e_w || rsp_error !== e_err) begin
        n_fail++;
        $display("FAIL call_rsp id=%0d blk=%b p=%h cyc=%0d: v=%b has=%b val=%h w=%0d err=%b expected 1 %b %h %0d %b",
                 id, blk, p, h, rsp_valid, rsp_has_val, rsp_val, rsp_width, rsp_error, e_has, e_val, e_w, e_err);
      end
      if (h < hold) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_has_val !== 1'b0 ||
        rsp_val !== 32'd0 || rsp_width !== 8'd0 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL call_after_hs: v=%b rdy=%b has=%b val=%h w=%0d err=%b expected 0 1 0 0 0 0",
               rsp_valid, req_ready, rsp_has_val, rsp_val, rsp_width, rsp_error);
    end
    n_checks++;
    if (inc_count !== m_inc || err_count !== 16'(m_err)) begin
      n_fail++;
      $display("FAIL call_counters: inc=%0d err=%0d expected %0d %0d", inc_count, err_count, m_inc, m_err);
    end
  endtask

  task automatic test_directed();
    do_call(16'd0, 1'b0, 32'd5, 0);
    do_call(16'd0, 1'b0, 32'h7FFF_FFFF, 1);
    do_call(16'd0, 1'b0, 32'hFFFF_FFFF, 0);
    do_call(16'd3, 1'b0, 32'd9, 0);
    do_call(16'd0, 1'b1, 32'd5, 3);
  endtask

  task automatic test_random();
    logic [15:0] id;
    for (int i = 0; i < 30; i++) begin
      id = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      do_call(id, 1'($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_call();
    do_call(16'd0, 1'b0, $urandom, 0);
    do_call(16'd7, 1'b0, $urandom, 0);
    req_valid = 1'b1; req_id = 16'd0; req_blocking = 1'b1; req_param = 32'd5;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    m_inc = 32'd0; m_err = 0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || def_valid !== 1'b0 ||
        inc_count !== 32'd0 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midcall_reset: v=%b rdy=%b defv=%b inc=%0d err=%0d expected 0 0 0 0 0",
               rsp_valid, req_ready, def_valid, inc_count, err_count);
    end
    tick();
    test_register();
    repeat (P_LAT + 2) tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midcall_no_rsp: rsp_valid=%b expected 0", rsp_valid);
    end
    do_call(16'd0, 1'b0, 32'd41, 0);
  endtask

  // Refused registration, plain nack and nack together with ready.
  task automatic test_fault();
    int k;
    for (int v = 0; v < 2; v++) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      k = 0;
      while (def_valid !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      def_nack = 1'b1;
      def_ready = (v == 1);
      tick();
      def_nack = 1'b0; def_ready = 1'b0;
      n_checks++;
      if (fault !== 1'b1 || req_ready !== 1'b0 || def_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_enter v=%0d: fault=%b rdy=%b defv=%b expected 1 0 0", v, fault, req_ready, def_valid);
      end
      req_valid = 1'b1; def_ready = 1'b1;
      repeat (5) tick();
      req_valid = 1'b0; def_ready = 1'b0;
      n_checks++;
      if (fault !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || def_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_hold v=%0d: fault=%b rdy=%b v=%b defv=%b expected 1 0 0 0",
                 v, fault, req_ready, rsp_valid, def_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_register();
    test_directed();
    test_random();
    test_reset_mid_call();
    test_fault();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
